// File: rtl/mem_responder.sv
// Single-port word memory behind a req/ready handshake with a fixed number of
// wait states per access and an error response for misaligned or out-of-range addresses.
module mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_write_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        mem_ready,
    output logic        mem_err,
    output logic [1:0]  state_dbg
);

    // Handshake: mem_req is a level held by the requester; it is sampled only
    // in IDLE, and the access completes with a one-cycle mem_ready pulse (mem_err
    // qualifies that pulse). Dropping or replacing the request is safe once
    // mem_ready=1 has been seen.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;

    logic [31:0] storage [DEPTH];

    logic                  enter_resp;
    logic [31:0]           cur_addr;
    logic                  cur_we;
    logic                  cur_err;
    logic [DEPTH_LOG2-1:0] cur_idx;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != 32'd0);
    endfunction

    // With zero wait states the response is formed on the accepting edge, so the
    // live inputs stand in for the not-yet-latched fields.
    always_comb begin
        cur_addr   = (state == S_IDLE) ? mem_write_addr : addr_q;
        cur_we     = (state == S_IDLE) ? mem_we : we_q;
        cur_err    = addr_bad(cur_addr);
        cur_idx    = cur_addr[DEPTH_LOG2+1:2];
        enter_resp = ((state == S_IDLE) && mem_req && (WAIT_CYCLES == 0)) ||
                     ((state == S_WAIT) && (cnt == 4'd0));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            cnt           <= 4'd0;
            we_q          <= 1'b0;
            addr_q        <= 32'd0;
            data_q        <= 32'd0;
            mem_ready     <= 1'b0;
            mem_err       <= 1'b0;
            mem_read_data <= 32'd0;
        end else begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_req) begin
                        we_q   <= mem_we;
                        addr_q <= mem_write_addr;
                        data_q <= mem_write_data;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (enter_resp) begin
                mem_ready <= 1'b1;
                mem_err   <= cur_err;
                if (cur_err) begin
                    mem_read_data <= 32'd0;
                end else if (!cur_we) begin
                    mem_read_data <= storage[cur_idx];
                end
            end
        end
    end

    // The write commits on the edge leaving RESP, so a reset during the access cancels it.
    always_ff @(posedge clk) begin
        if (rst && (state == S_RESP) && we_q && !addr_bad(addr_q)) begin
            storage[addr_q[DEPTH_LOG2+1:2]] <= data_q;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and one
// with none, driven from a vector table plus hand-written multi-cycle sequences.
module tb_mem_responder;

    logic clk;
    logic rst;

    logic        req2, we2, ready2, err2;
    logic [31:0] addr2, wdata2, rdata2;
    logic [1:0]  st2;

    logic        req0, we0, ready0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [1:0]  st0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        int          which;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [18];

    mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut_w2 (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (req2),
        .mem_we         (we2),
        .mem_write_addr (addr2),
        .mem_write_data (wdata2),
        .mem_read_data  (rdata2),
        .mem_ready      (ready2),
        .mem_err        (err2),
        .state_dbg      (st2)
    );

    mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut_w0 (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (req0),
        .mem_we         (we0),
        .mem_write_addr (addr0),
        .mem_write_data (wdata0),
        .mem_read_data  (rdata0),
        .mem_ready      (ready0),
        .mem_err        (err0),
        .state_dbg      (st0)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic set_req(input int which, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        if (which == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req2 = r; we2 = w; addr2 = a; wdata2 = d;
        end
    endtask

    function automatic logic get_ready(input int which);
        return (which == 0) ? ready0 : ready2;
    endfunction

    function automatic logic get_err(input int which);
        return (which == 0) ? err0 : err2;
    endfunction

    function automatic logic [31:0] get_rdata(input int which);
        return (which == 0) ? rdata0 : rdata2;
    endfunction

    // Scoreboard compare
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One full access: drive, wait (bounded) for mem_ready, compare, drop, confirm single pulse.
    task automatic access(input int which, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int exp_lat, input logic exp_err,
                          input string tag);
        int lat;
        logic [31:0] exp_d;
        @(negedge clk);
        set_req(which, 1'b1, w, a, d);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!get_ready(which) && lat < 20);
        check({tag, " ready"}, 32'(get_ready(which)), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " err"}, 32'(get_err(which)), 32'(exp_err));
        exp_d = exp_q.pop_front();
        check({tag, " rdata"}, get_rdata(which), exp_d);
        set_req(which, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check({tag, " single pulse"}, 32'(get_ready(which)), 32'd0);
        check({tag, " err idle"}, 32'(get_err(which)), 32'd0);
    endtask

    initial begin
        logic [31:0] held_addr [3];
        logic [31:0] held_exp  [3];
        int cyc;

        vecs[0]  = '{2, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 3};
        vecs[1]  = '{2, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 3};
        vecs[2]  = '{2, 1'b1, 32'h0000_0013, 32'h0000_0001, 32'h0000_0000, 1'b1, 3};
        vecs[3]  = '{2, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 3};
        vecs[4]  = '{2, 1'b0, 32'h0000_0400, 32'h0000_0000, 32'h0000_0000, 1'b1, 3};
        vecs[5]  = '{2, 1'b1, 32'h0000_0020, 32'hAAAA_5555, 32'h0000_0000, 1'b0, 3};
        vecs[6]  = '{2, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'hAAAA_5555, 1'b0, 3};
        vecs[7]  = '{2, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'hAAAA_5555, 1'b0, 3};
        vecs[8]  = '{2, 1'b1, 32'h0000_0004, 32'h2222_2222, 32'hAAAA_5555, 1'b0, 3};
        vecs[9]  = '{2, 1'b1, 32'h0000_0008, 32'h3333_3333, 32'hAAAA_5555, 1'b0, 3};
        vecs[10] = '{2, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'hAAAA_5555, 1'b0, 3};
        vecs[11] = '{2, 1'b0, 32'h0000_03FC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 3};
        vecs[12] = '{2, 1'b0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 3};
        vecs[13] = '{0, 1'b1, 32'h0000_0004, 32'h1234_5678, 32'h0000_0000, 1'b0, 1};
        vecs[14] = '{0, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h1234_5678, 1'b0, 1};
        vecs[15] = '{0, 1'b0, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
        vecs[16] = '{0, 1'b1, 32'h0000_0008, 32'h9ABC_DEF0, 32'h0000_0000, 1'b0, 1};
        vecs[17] = '{0, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h9ABC_DEF0, 1'b0, 1};

        rst = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(2, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        check("reset ready w2", 32'(ready2), 32'd0);
        check("reset err w2", 32'(err2), 32'd0);
        check("reset rdata w2", rdata2, 32'd0);
        check("reset state w2", 32'(st2), 32'd0);
        check("reset ready w0", 32'(ready0), 32'd0);
        check("reset rdata w0", rdata0, 32'd0);
        check("reset state w0", 32'(st0), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            exp_q.push_back(vecs[i].exp_rdata);
            access(vecs[i].which, vecs[i].we, vecs[i].addr, vecs[i].data,
                   vecs[i].exp_lat, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Request held across three reads; the address is scrambled during WAIT.
        held_addr[0] = 32'h0000_0000; held_exp[0] = 32'h1111_1111;
        held_addr[1] = 32'h0000_0004; held_exp[1] = 32'h2222_2222;
        held_addr[2] = 32'h0000_0008; held_exp[2] = 32'h3333_3333;
        @(negedge clk);
        set_req(2, 1'b1, 1'b0, held_addr[0], 32'd0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(held_exp[i]);
            @(negedge clk);
            addr2 = 32'h0000_03FC;
            cyc = 1;
            while (!ready2 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            check($sformatf("held%0d ready", i), 32'(ready2), 32'd1);
            check($sformatf("held%0d latency", i), 32'(cyc), 32'd3);
            check($sformatf("held%0d err", i), 32'(err2), 32'd0);
            check($sformatf("held%0d rdata", i), rdata2, exp_q.pop_front());
            if (i < 2) addr2 = held_addr[i+1];
            else req2 = 1'b0;
            @(negedge clk);
            check($sformatf("held%0d single pulse", i), 32'(ready2), 32'd0);
        end

        // Reset during WAIT of a write to 0x20 cancels the write and the response.
        @(negedge clk);
        set_req(2, 1'b1, 1'b1, 32'h0000_0020, 32'hBAD0_BAD0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstwait ready", 32'(ready2), 32'd0);
        check("rstwait err", 32'(err2), 32'd0);
        check("rstwait rdata", rdata2, 32'd0);
        rst = 1'b1;
        set_req(2, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ready2) cyc++;
        end
        check("rstwait no pulse", 32'(cyc), 32'd0);
        exp_q.push_back(32'hAAAA_5555);
        access(2, 1'b0, 32'h0000_0020, 32'd0, 3, 1'b0, "rstwait readback");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, log2 of the storage depth in 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, number of wait states inserted per access; legal range 0..15.
REQ-003 clk  input  1  single clock for the block; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 mem_req  input  1  access request from the processor, level-sensitive.
REQ-006 mem_we  input  1  write enable: 1 selects write, 0 selects read; sampled at accept.
REQ-007 mem_write_addr  input  32  byte address for both reads and writes; sampled at accept.
REQ-008 mem_write_data  input  32  write data; sampled at accept.
REQ-009 mem_read_data  output  32  registered read data.
REQ-010 mem_ready  output  1  one-cycle pulse marking completion of the accepted access.
REQ-011 mem_err  output  1  error flag, valid only while mem_ready=1.

Function
REQ-012 Storage SHALL be 2^DEPTH_LOG2 words of 32 bits, not reset; the word index is mem_write_addr[DEPTH_LOG2+1:2].
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-014 In IDLE with mem_req=1 at an edge, the block SHALL accept the request and latch mem_we, mem_write_addr and mem_write_data.
- On accept, the block SHALL move to WAIT with the wait counter loaded to WAIT_CYCLES-1.
- If WAIT_CYCLES=0, the block SHALL move directly to RESP instead.
REQ-015 In WAIT, the counter SHALL decrement each cycle; the block SHALL move to RESP at the edge where the counter equals 0.
REQ-016 Latency: request sampled at edge k -> mem_ready=1 during the cycle following edge k+WAIT_CYCLES, i.e. WAIT_CYCLES+1 cycles.
REQ-017 In RESP, mem_ready SHALL be 1 for exactly one cycle, and the block SHALL return to IDLE unconditionally at the next edge.
REQ-018 mem_req SHALL be ignored in WAIT and RESP; latched fields SHALL NOT change after accept.
REQ-019 Handshake: the requester holds mem_req until it samples mem_ready=1, then drops or replaces the request.
- A request present in the cycle after RESP SHALL be accepted as a new access, giving one-cycle spacing between back-to-back accesses.
REQ-020 Error condition: latched address bits [1:0]!=0, or any latched address bit above DEPTH_LOG2+1 set.
REQ-021 In RESP on error: mem_err SHALL be 1, storage SHALL be unchanged, and mem_read_data SHALL be set to 0.
REQ-022 Valid write: storage[index] SHALL be updated at the edge leaving RESP; mem_read_data SHALL hold its previous value.
REQ-023 Valid read: mem_read_data SHALL show storage[index] during the RESP cycle.
- mem_read_data SHALL hold that value until the next read or error response.
REQ-024 A read in RESP of a word written by the immediately preceding access SHALL return the newly written data.
REQ-025 mem_err SHALL be 0 whenever mem_ready=0.

Reset
REQ-026 While rst=0 at an edge, the block SHALL go to IDLE with the wait counter set to 0, mem_ready=0, mem_err=0 and mem_read_data=0.
REQ-027 Reset in WAIT or RESP SHALL abort the access: no storage write and no mem_ready pulse.
REQ-028 The first request after reset SHALL be accepted no earlier than the first edge with rst=1.

Verification
REQ-029 Write then read, WAIT_CYCLES=2:
- write addr 0x10, data 0xDEADBEEF -> mem_ready 3 cycles after accept, mem_err=0;
- read addr 0x10 -> mem_read_data=0xDEADBEEF with mem_ready.
REQ-030 WAIT_CYCLES=0:
- write addr 0x4, data 0x12345678, then read addr 0x4 -> mem_ready 1 cycle after each accept;
- read returns 0x12345678.
REQ-031 Misaligned write to 0x13 with data 0x1 -> mem_err=1 with mem_ready, mem_read_data=0; subsequent read of 0x10 still returns 0xDEADBEEF.
REQ-032 Out-of-range read of 0x400 with DEPTH_LOG2=8 -> mem_err=1, mem_read_data=0, single mem_ready pulse.
REQ-033 mem_req held continuously for 3 reads of 0x0, 0x4 and 0x8:
- exactly one mem_ready per access;
- accepts spaced WAIT_CYCLES+2 cycles apart;
- address changes made during WAIT have no effect on the data returned.
REQ-034 rst=0 asserted during WAIT of a write to 0x20 -> no mem_ready; a later read of 0x20 returns the prior contents; all outputs 0 in the cycle after reset.
